// File: rtl/btn_debounce_pulse.sv
// Purpose: synchronise and debounce raw pad buttons, emitting a clean level plus one-cycle rise/fall pulses.
// Latency: a raw change captured at edge E shows on btn_level/btn_rise/btn_fall at edge E + SYNC_STAGES + DB_CYCLES - 1.
// Backpressure: none; en=0 freezes debounce state and suppresses pulses, while the synchroniser keeps running.
module btn_debounce_pulse #(
    parameter int N_BTN       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_WAIT_HI,
        ST_HIGH,
        ST_WAIT_LO
    } state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_t                 state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;

        assign s = sync_q[SYNC_STAGES-1];

        // Synchroniser chain; free-running so it never holds a stale sample across en.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
            end
        end

        // Next-state: a change must be seen DB_CYCLES consecutive samples; any reversal aborts.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (en) begin
                unique case (state_q)
                    ST_LOW: begin
                        if (s) begin
                            state_d = ST_WAIT_HI;
                            cnt_d   = CNT_ONE;
                        end
                    end
                    ST_WAIT_HI: begin
                        if (!s) begin
                            state_d = ST_LOW;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = ST_HIGH;
                            cnt_d   = '0;
                            level_d = 1'b1;
                            rise_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (!s) begin
                            state_d = ST_WAIT_LO;
                            cnt_d   = CNT_ONE;
                        end
                    end
                    ST_WAIT_LO: begin
                        if (s) begin
                            state_d = ST_HIGH;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = ST_LOW;
                            cnt_d   = '0;
                            level_d = 1'b0;
                            fall_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        // State, counter and registered outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_LOW;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign btn_level[i] = level_q;
        assign btn_rise[i]  = rise_q;
        assign btn_fall[i]  = fall_q;
    end

endmodule
